// File: rtl/range_fix_pkg.sv
// rtl/range_fix_pkg.sv - shared widths, state encoding and floor-mod-100 helper for range_fix_arbiter
package range_fix_pkg;

    localparam int MOD_BASE = 100;
    localparam int VAL_W    = 10;
    localparam int RES_W    = 7;

    typedef enum logic [1:0] {IDLE, CALC, RESP} rfa_state_t;

    // Biasing by 600 (a multiple of 100 larger than 512) makes every operand
    // non-negative, so an unsigned remainder equals the floor modulo.
    function automatic logic [RES_W-1:0] floor_mod100(input logic [VAL_W-1:0] x);
        logic [VAL_W:0] biased;
        biased = {x[VAL_W-1], x} + (VAL_W+1)'(6 * MOD_BASE);
        return RES_W'(biased % (VAL_W+1)'(MOD_BASE));
    endfunction

endpackage

// File: rtl/range_mod100_pipe.sv
// rtl/range_mod100_pipe.sv - signed 10-bit to 0..99 floor-modulo reducer with LAT register stages
module range_mod100_pipe
    import range_fix_pkg::*;
#(
    parameter int LAT = 2
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [VAL_W-1:0] in_val,
    output logic [RES_W-1:0] out_val
);

    logic [RES_W-1:0] stage [LAT];

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int i = 0; i < LAT; i++) stage[i] <= '0;
        end else begin
            stage[0] <= floor_mod100(in_val);
            for (int i = 1; i < LAT; i++) stage[i] <= stage[i-1];
        end
    end

    assign out_val = stage[LAT-1];

endmodule

// File: rtl/range_fix_arbiter.sv
// rtl/range_fix_arbiter.sv - round-robin arbiter sharing one mod-100 reducer; RANGE_FIX_ARB_CNT_EN adds grant_cnt
module range_fix_arbiter
    import range_fix_pkg::*;
#(
    parameter int N_REQ = 4,
    parameter int ID_W  = 2,
    parameter int LAT   = 2
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic [N_REQ-1:0]       req_valid,
    input  logic [VAL_W*N_REQ-1:0] req_val,
    output logic [N_REQ-1:0]       req_ready,
    output logic                   rsp_valid,
    output logic [RES_W-1:0]       rsp_val,
    output logic [ID_W-1:0]        rsp_id,
    input  logic                   rsp_ready,
    output logic                   busy
`ifdef RANGE_FIX_ARB_CNT_EN
    ,
    output logic [15:0]            grant_cnt
`endif
);

    localparam logic [2:0] CALC_LAST = 3'(LAT - 1);

    rfa_state_t       state, state_n;
    logic [ID_W-1:0]  rr_ptr;
    logic [2:0]       calc_cnt;
    logic             grant_any;
    logic [ID_W-1:0]  grant_idx;
    logic             grant_fire;
    logic [VAL_W-1:0] op_sel;
    logic [RES_W-1:0] pipe_out;

    // Search starts just after the last winner, so a continuously valid
    // requester cannot starve the others.
    always_comb begin
        grant_any = 1'b0;
        grant_idx = '0;
        for (int k = 1; k <= N_REQ; k++) begin
            if (!grant_any && req_valid[(int'(rr_ptr) + k) % N_REQ]) begin
                grant_any = 1'b1;
                grant_idx = ID_W'((int'(rr_ptr) + k) % N_REQ);
            end
        end
    end

    assign grant_fire = (state == IDLE) && grant_any;

    always_comb begin
        req_ready = '0;
        if (grant_fire) req_ready[grant_idx] = 1'b1;
    end

    // The reducer's first stage captures the granted operand on the grant edge.
    assign op_sel = req_val[VAL_W*grant_idx +: VAL_W];

    range_mod100_pipe #(.LAT(LAT)) u_pipe (
        .clk     (clk),
        .rst     (rst),
        .in_val  (op_sel),
        .out_val (pipe_out)
    );

    always_ff @(posedge clk or posedge rst) begin
        if (rst) state <= IDLE;
        else     state <= state_n;
    end

    always_comb begin
        state_n = state;
        case (state)
            IDLE:    if (grant_any) state_n = CALC;
            CALC:    if (calc_cnt == CALC_LAST) state_n = RESP;
            RESP:    if (rsp_ready) state_n = IDLE;
            default: state_n = IDLE;
        endcase
    end

    // rr_ptr doubles as the owner id of the operation in flight.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            rr_ptr    <= ID_W'(N_REQ - 1);
            calc_cnt  <= '0;
            rsp_valid <= 1'b0;
            rsp_val   <= '0;
            rsp_id    <= '0;
        end else begin
            case (state)
                IDLE: begin
                    if (grant_any) begin
                        rr_ptr   <= grant_idx;
                        calc_cnt <= '0;
                    end
                end
                CALC: begin
                    calc_cnt <= calc_cnt + 3'd1;
                    if (calc_cnt == CALC_LAST) begin
                        rsp_valid <= 1'b1;
                        rsp_val   <= pipe_out;
                        rsp_id    <= rr_ptr;
                    end
                end
                RESP: begin
                    if (rsp_ready) rsp_valid <= 1'b0;
                end
                default: ;
            endcase
        end
    end

    assign busy = (state != IDLE);

`ifdef RANGE_FIX_ARB_CNT_EN
    always_ff @(posedge clk or posedge rst) begin
        if (rst)                                  grant_cnt <= '0;
        else if (grant_fire && grant_cnt != 16'hFFFF) grant_cnt <= grant_cnt + 16'd1;
    end
`endif

endmodule

// File: tb/tb_range_fix_arbiter.sv
// tb/tb_range_fix_arbiter.sv - directed table-driven bench for range_fix_arbiter (N_REQ=4, LAT=2)
module tb_range_fix_arbiter;

    localparam int N_REQ = 4;
    localparam int ID_W  = 2;
    localparam int LAT   = 2;

    logic         clk = 1'b0;
    logic         rst = 1'b1;
    logic [3:0]   req_valid = '0;
    logic [39:0]  req_val = '0;
    logic [3:0]   req_ready;
    logic         rsp_valid;
    logic [6:0]   rsp_val;
    logic [1:0]   rsp_id;
    logic         rsp_ready = 1'b0;
    logic         busy;
`ifdef RANGE_FIX_ARB_CNT_EN
    logic [15:0]  grant_cnt;
`endif

    int n_pass = 0;
    int n_total = 0;

    range_fix_arbiter #(.N_REQ(N_REQ), .ID_W(ID_W), .LAT(LAT)) dut (
        .clk       (clk),
        .rst       (rst),
        .req_valid (req_valid),
        .req_val   (req_val),
        .req_ready (req_ready),
        .rsp_valid (rsp_valid),
        .rsp_val   (rsp_val),
        .rsp_id    (rsp_id),
        .rsp_ready (rsp_ready),
        .busy      (busy)
`ifdef RANGE_FIX_ARB_CNT_EN
        ,
        .grant_cnt (grant_cnt)
`endif
    );

    always #5 clk = ~clk;

    typedef struct {
        int         idx;
        logic [9:0] val;
        logic [6:0] exp;
    } vec_t;

    vec_t vecs[6];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_total++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %0d expected %0d", name, act, exp);
    endtask

    task automatic do_reset();
        rst = 1'b1;
        req_valid = '0;
        @(negedge clk);
        @(negedge clk);
        rst = 1'b0;
    endtask

    // One isolated transaction; checks grant, latency, result, id and release.
    task automatic run_one(input int idx, input logic [9:0] val, input logic [6:0] exp, input string name);
        int cyc;
        int lat;
        @(negedge clk);
        req_val[10*idx +: 10] = val;
        req_valid = 4'b0001 << idx;
        rsp_ready = 1'b1;
        #1;
        cyc = 0;
        while (!req_ready[idx] && cyc < 20) begin
            @(negedge clk);
            #1;
            cyc++;
        end
        check({name, "_grant"}, 32'(req_ready), 32'(4'b0001 << idx));
        @(negedge clk);
        req_valid = '0;
        lat = 1;
        while (!rsp_valid && lat < 20) begin
            @(negedge clk);
            lat++;
        end
        check({name, "_latency"}, lat, LAT + 1);
        check({name, "_val"}, 32'(rsp_val), 32'(exp));
        check({name, "_id"}, 32'(rsp_id), idx);
        @(negedge clk);
        check({name, "_release"}, {30'd0, rsp_valid, busy}, 32'd0);
    endtask

    initial begin
        int   ids[$];
        int   vals[$];
        int   stamps[$];
        int   exp_ids[5];
        int   exp_vals[5];
        int   cyc;
        logic ok;
        logic seen;

        vecs[0] = '{1, 10'h388, 7'd80};  // -120
        vecs[1] = '{2, 10'h200, 7'd88};  // -512
        vecs[2] = '{2, 10'h1FF, 7'd11};  //  511
        vecs[3] = '{0, 10'h39C, 7'd0};   // -100
        vecs[4] = '{3, 10'h3FF, 7'd99};  //   -1
        vecs[5] = '{1, 10'h0FA, 7'd50};  //  250
        exp_ids  = '{0, 1, 2, 3, 0};
        exp_vals = '{0, 99, 0, 99, 0};

        #1;
        check("reset_outputs", {rsp_valid, rsp_val, rsp_id, req_ready, busy}, 32'd0);
        do_reset();
        #1;
        check("idle_no_grant", {req_ready, busy, rsp_valid}, 32'd0);

        for (int i = 0; i < 6; i++)
            run_one(vecs[i].idx, vecs[i].val, vecs[i].exp, $sformatf("vec%0d", i));

        // All requesters valid after reset: strict rotation, one result per LAT+2 cycles.
        do_reset();
        @(negedge clk);
        req_val = {10'h3FF, 10'd100, 10'd99, 10'd0};
        req_valid = 4'b1111;
        rsp_ready = 1'b1;
        cyc = 0;
        while (ids.size() < 5 && cyc < 60) begin
            @(negedge clk);
            cyc++;
            if (rsp_valid) begin
                ids.push_back(int'(rsp_id));
                vals.push_back(int'(rsp_val));
                stamps.push_back(cyc);
            end
        end
        check("rot_count", ids.size(), 5);
        for (int i = 0; i < 5 && i < ids.size(); i++) begin
            check($sformatf("rot_id%0d", i), ids[i], exp_ids[i]);
            check($sformatf("rot_val%0d", i), vals[i], exp_vals[i]);
            if (i > 0) check($sformatf("rot_gap%0d", i), stamps[i] - stamps[i-1], LAT + 2);
        end

        // Back-pressure: stall in RESP, no new grants.
        do_reset();
        @(negedge clk);
        rsp_ready = 1'b0;
        req_val = {10'd0, 10'd7, 10'h1FF, 10'd0};
        req_valid = 4'b0110;
        #1;
        check("stall_first_grant", 32'(req_ready), 32'h2);
        cyc = 0;
        while (!rsp_valid && cyc < 20) begin
            @(negedge clk);
            cyc++;
        end
        check("stall_rsp", {rsp_valid, rsp_val, rsp_id}, {22'd0, 1'b1, 7'd11, 2'd1});
        ok = 1'b1;
        for (int i = 0; i < 10; i++) begin
            @(negedge clk);
            if ({rsp_valid, rsp_val, rsp_id, req_ready, busy} !== {1'b1, 7'd11, 2'd1, 4'd0, 1'b1}) ok = 1'b0;
        end
        check("stall_stable", 32'(ok), 32'd1);
        rsp_ready = 1'b1;
        @(negedge clk);
        check("stall_released", {rsp_valid, req_ready}, {27'd0, 1'b0, 4'b0100});

        // Reset during CALC discards the operation.
        @(negedge clk);
        req_valid = '0;
        check("calc_busy", 32'(busy), 32'd1);
        #2;
        rst = 1'b1;
        #1;
        check("async_rst_outputs", {rsp_valid, rsp_val, rsp_id, req_ready, busy}, 32'd0);
        @(negedge clk);
        rst = 1'b0;
        seen = 1'b0;
        for (int i = 0; i < 10; i++) begin
            @(negedge clk);
            if (rsp_valid) seen = 1'b1;
        end
        check("no_rsp_after_rst", 32'(seen), 32'd0);
        req_valid = 4'b1111;
        #1;
        check("first_grant_after_rst", 32'(req_ready), 32'h1);
        @(negedge clk);
        req_valid = '0;

`ifdef RANGE_FIX_ARB_CNT_EN
        do_reset();
        check("cnt_reset", 32'(grant_cnt), 32'd0);
        for (int i = 0; i < 5; i++)
            run_one(vecs[i].idx, vecs[i].val, vecs[i].exp, $sformatf("cnt%0d", i));
        check("cnt_five", 32'(grant_cnt), 32'd5);
        force dut.grant_cnt = 16'hFFFF;
        @(negedge clk);
        release dut.grant_cnt;
        run_one(0, 10'd42, 7'd42, "cnt_sat_op");
        check("cnt_saturate", 32'(grant_cnt), 32'hFFFF);
`endif

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
